// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback port arbiter.
// Holds the RF address width, data width and the queued result entry.
package wb_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int WB_WIDTH  = 32;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] rd;
    logic [WB_WIDTH-1:0]  data;
    logic                 kill;
  } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small in-order FIFO of MDU results with a per-entry WAW kill port.
// Ports: clk/rst, push/push_rd/push_data, pop, kill/kill_rd, head, full, empty.
module wb_result_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [RF_ADDR_W-1:0] push_rd,
  input  logic [WB_WIDTH-1:0]  push_data,
  input  logic                 pop,
  input  logic                 kill,
  input  logic [RF_ADDR_W-1:0] kill_rd,
  output wb_entry_t            head,
  output logic                 full,
  output logic                 empty
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Per-slot valid bits give occupancy directly.
  assign empty = ~|vld;
  assign full  = &vld;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      // Only entries stored before this edge can be killed;
      // the slot being written now is not valid yet.
      for (int i = 0; i < DEPTH; i++) begin
        if (kill && vld[i] && mem[i].rd == kill_rd) begin
          mem[i].kill <= 1'b1;
        end
      end
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        mem[wr_ptr] <= '{rd: push_rd, data: push_data, kill: 1'b0};
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single RF write port between pipeline WB and queued MDU results.
// Ports: pipe_* request/ready, mdu_* request/ready, registered rf_* write, mdu_pending_out.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int WIDTH        = WB_WIDTH,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             pipe_valid_in,
  output logic             pipe_ready_out,
  input  logic             pipe_sel_in,
  input  logic [4:0]       pipe_rd_in,
  input  logic [WIDTH-1:0] pipe_data_in,
  input  logic [WIDTH-1:0] pipe_alu_res_in,
  input  logic             mdu_valid_in,
  output logic             mdu_ready_out,
  input  logic [4:0]       mdu_rd_in,
  input  logic [WIDTH-1:0] mdu_res_in,
  output logic             rf_we_out,
  output logic [4:0]       rf_rd_out,
  output logic [WIDTH-1:0] rf_wdata_out,
  output logic             mdu_pending_out
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  wb_entry_t        head;
  logic             full;
  logic             empty;
  logic             starved;
  logic             head_win;
  logic             pipe_acc;
  logic             mdu_push;
  logic             kill;
  logic [WIDTH-1:0] pipe_wdata;
  logic [CNT_W-1:0] wait_cnt;

  // Head wins when the pipe is idle, the queue is full,
  // or the head has lost STARVE_LIMIT times in a row.
  assign starved  = (wait_cnt == CNT_W'(STARVE_LIMIT));
  assign head_win = !empty && (!pipe_valid_in || full || starved);
  assign pipe_acc = pipe_valid_in && !head_win;

  assign pipe_ready_out  = !head_win;
  assign mdu_ready_out   = !full;
  assign mdu_pending_out = !empty;

  assign mdu_push   = mdu_valid_in && !full;
  assign kill       = pipe_acc && (pipe_rd_in != '0);
  assign pipe_wdata = pipe_sel_in ? pipe_data_in : pipe_alu_res_in;

  wb_result_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk_in),
    .rst      (rst_in),
    .push     (mdu_push),
    .push_rd  (mdu_rd_in),
    .push_data(mdu_res_in),
    .pop      (head_win),
    .kill     (kill),
    .kill_rd  (pipe_rd_in),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wait_cnt     <= '0;
      rf_we_out    <= 1'b0;
      rf_rd_out    <= '0;
      rf_wdata_out <= '0;
    end else begin
      if (empty || head_win) begin
        wait_cnt <= '0;
      end else if (!starved) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end

      // x0 and killed winners still consume the grant.
      if (head_win) begin
        rf_we_out    <= (head.rd != '0) && !head.kill;
        rf_rd_out    <= head.rd;
        rf_wdata_out <= head.data;
      end else if (pipe_acc) begin
        rf_we_out    <= (pipe_rd_in != '0);
        rf_rd_out    <= pipe_rd_in;
        rf_wdata_out <= pipe_wdata;
      end else begin
        rf_we_out <= 1'b0;
      end
    end
  end

endmodule
